fft_frame_ctrl: RTL and testbench
=================================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter NN, default 32, meaning samples per FFT frame (power of 2, 8..1024).
REQ-002 SHALL have parameter DW, default 16, meaning sample data width.
REQ-003 SHALL have parameter GAP, default 16, meaning idle cycles between frames when FFT_FRAME_GAP_EN is defined.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port fifo_full  input  1  sample FIFO full flag; its rising edge is the frame start request.
REQ-007 SHALL have port fifo_empty  input  1  sample FIFO empty flag; the FIFO is show-ahead, so fifo_q is valid whenever fifo_empty=0.
REQ-008 SHALL have port fifo_q  input  DW  FIFO head sample.
REQ-009 SHALL have port fifo_rdreq  output  1  combinational pop of the FIFO head.
REQ-010 SHALL have port sink_ready  input  1  FFT core sink backpressure.
REQ-011 SHALL have ports sink_valid, sink_sop, sink_eop  output  1 each  registered FFT sink framing.
REQ-012 SHALL have port sink_data  output  DW  registered sample to the FFT core.
REQ-013 SHALL have port source_eop  input  1  FFT core output end-of-frame, qualified by source_valid.
REQ-014 SHALL have port source_valid  input  1  FFT core output valid.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port frame_cnt  output  16  completed frames; wraps 0xFFFF->0.
REQ-017 SHALL have ports underrun, missed  output  1 each  sticky error flags.

Function
REQ-018 SHALL register fifo_full twice and detect start as prev=0, cur=1 (2-cycle start latency).
REQ-019 SHALL implement the FSM IDLE->STREAM->DRAIN->(GAP)->IDLE.
REQ-020 IDLE: on start, SHALL load the sample counter with 0, clear underrun and enter STREAM.
REQ-021 STREAM: a sample SHALL load into the output register when fifo_empty=0 and (sink_valid=0 or sink_ready=1); fifo_rdreq SHALL equal that load condition.
REQ-022 A sink transfer SHALL be defined as sink_valid and sink_ready both high; sink_valid SHALL drop after a transfer if no new sample loads.
REQ-023 sink_sop SHALL be high with the first sample (index 0) and sink_eop with sample NN-1; both SHALL be held stable with sink_valid while sink_ready=0.
REQ-024 SHALL load exactly NN samples per frame; after loading sample NN-1, the FSM SHALL enter DRAIN once that sample transfers.
REQ-025 fifo_empty=1 in STREAM with samples remaining SHALL cause a bubble (sink_valid=0) and set underrun; streaming SHALL resume when data returns.
REQ-026 DRAIN: on source_valid and source_eop, frame_cnt SHALL increment and the FSM SHALL go to GAP, or to IDLE if gap is disabled.
REQ-027 A start event while busy=1 SHALL be ignored and SHALL set missed; missed SHALL clear only on reset.
REQ-028 A start event in the same cycle that the FSM returns to IDLE SHALL be ignored (missed set); only a start seen in IDLE SHALL begin a frame.
REQ-029 fifo_rdreq SHALL never be asserted when fifo_empty=1 or outside STREAM.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, the counters and frame_cnt to 0, all sink_* outputs, fifo_rdreq, busy, underrun, missed and the edge detector to 0.
REQ-031 Reset mid-frame SHALL abort the frame with no eop; after release, the block SHALL wait for a fresh fifo_full rising edge.

Configuration
REQ-032 With FFT_FRAME_GAP_EN defined, GAP SHALL hold for GAP cycles (busy=1, no reads) before IDLE; without it, DRAIN SHALL go directly to IDLE and the GAP parameter SHALL be unused.

Verification
REQ-033 Scenario: NN=32, sink_ready=1, FIFO stays non-empty, fifo_full rises -> 32 consecutive valids, sop on the first, eop on the 32nd, 32 rdreq pulses.
REQ-034 Scenario: sink_ready toggles 1/0 every cycle -> still exactly 32 transfers, data order preserved, sop/eop held while stalled.
REQ-035 Scenario: fifo_empty=1 for 3 cycles at sample 10 -> 3-cycle valid gap, underrun=1, frame still completes with 32 samples.
REQ-036 Scenario: second fifo_full edge during STREAM -> missed=1, no extra frame; after source_eop, frame_cnt=1.
REQ-037 Scenario: rst_n pulsed low at sample 15 -> all outputs 0 immediately, no eop, no further reads until a new edge.
REQ-038 Scenario: FFT_FRAME_GAP_EN defined, GAP=16 -> busy stays 1 for 16 cycles after source_eop, then IDLE; undefined -> IDLE on the next cycle.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// Frames samples from a show-ahead FIFO into an FFT core sink, one NN-sample frame per fifo_full edge.
// Defining FFT_FRAME_GAP_EN adds a GAP-cycle idle period after each frame before returning to idle.
module fft_frame_ctrl #(
  parameter int NN  = 32,
  parameter int DW  = 16,
  parameter int GAP = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fifo_full,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_q,
  output logic          fifo_rdreq,
  input  logic          sink_ready,
  output logic          sink_valid,
  output logic          sink_sop,
  output logic          sink_eop,
  output logic [DW-1:0] sink_data,
  input  logic          source_eop,
  input  logic          source_valid,
  output logic          busy,
  output logic [15:0]   frame_cnt,
  output logic          underrun,
  output logic          missed
);

  localparam int CW = $clog2(NN) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          full_s1_q, full_s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic [DW-1:0] data_q, data_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          underrun_q, underrun_d;
  logic          missed_q, missed_d;

  logic start;
  logic all_loaded;
  logic xfer;
  logic load;

`ifdef FFT_FRAME_GAP_EN
  localparam int GW = $clog2(GAP + 1);
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`endif

  assign start      = full_s1_q & ~full_s2_q;
  assign all_loaded = (cnt_q == CW'(NN));
  assign xfer       = valid_q & sink_ready;
  // The output register refills in the same cycle it empties, so full rate is kept under ready=1.
  assign load       = (state_q == ST_STREAM) & ~fifo_empty & ~all_loaded & (~valid_q | sink_ready);

  assign fifo_rdreq = load;
  assign busy       = (state_q != ST_IDLE);
  assign sink_valid = valid_q;
  assign sink_sop   = sop_q;
  assign sink_eop   = eop_q;
  assign sink_data  = data_q;
  assign frame_cnt  = frame_cnt_q;
  assign underrun   = underrun_q;
  assign missed     = missed_q;

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;
    underrun_d  = underrun_q;
    missed_d    = missed_q;
`ifdef FFT_FRAME_GAP_EN
    gap_cnt_d   = gap_cnt_q;
`endif

    if (start && (state_q != ST_IDLE)) missed_d = 1'b1;

    if (load) begin
      data_d  = fifo_q;
      valid_d = 1'b1;
      sop_d   = (cnt_q == '0);
      eop_d   = (cnt_q == CW'(NN - 1));
      cnt_d   = cnt_q + CW'(1);
    end else if (xfer) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d      = '0;
          underrun_d = 1'b0;
          state_d    = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (fifo_empty && !all_loaded) underrun_d = 1'b1;
        if (xfer && eop_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (source_valid && source_eop) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef FFT_FRAME_GAP_EN
          gap_cnt_d   = '0;
          state_d     = ST_GAP;
`else
          state_d     = ST_IDLE;
`endif
        end
      end
      ST_GAP: begin
`ifdef FFT_FRAME_GAP_EN
        if (gap_cnt_q == GW'(GAP - 1)) state_d = ST_IDLE;
        else                           gap_cnt_d = gap_cnt_q + GW'(1);
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the sample register is reset too, so a mid-frame abort leaves no stale data on the sink bus.
      state_q     <= ST_IDLE;
      full_s1_q   <= 1'b0;
      full_s2_q   <= 1'b0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      data_q      <= '0;
      frame_cnt_q <= '0;
      underrun_q  <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_s1_q   <= fifo_full;
      full_s2_q   <= full_s1_q;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
      underrun_q  <= underrun_d;
      missed_q    <= missed_d;
    end
  end

`ifdef FFT_FRAME_GAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_cnt_q <= '0;
    else        gap_cnt_q <= gap_cnt_d;
  end
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: a FIFO model feeds samples, a monitor checks every sink beat.
module tb_fft_frame_ctrl;
  localparam int NN = 32;
  localparam int DW = 16;
`ifdef FFT_FRAME_GAP_EN
  localparam int EXP_GAP = 16;
`else
  localparam int EXP_GAP = 0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n, fifo_full, fifo_empty, fifo_rdreq, sink_ready;
  logic          sink_valid, sink_sop, sink_eop, source_eop, source_valid;
  logic          busy, underrun, missed;
  logic [DW-1:0] fifo_q, sink_data;
  logic [15:0]   frame_cnt;

  int total = 0;
  int bad   = 0;
  beat_t exp_q[$];

  logic [DW-1:0] fifo_val = 16'h1000;
  int  rd_count     = 0;
  int  hole_at      = -1;
  int  hole_done_at = -1;
  int  hole_left    = 0;
  bit  ready_toggle = 1'b0;
  bit  in_frame     = 1'b0;
  int  bubbles      = 0;

  fft_frame_ctrl #(.NN(NN), .DW(DW), .GAP(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_q       (fifo_q),
    .fifo_rdreq   (fifo_rdreq),
    .sink_ready   (sink_ready),
    .sink_valid   (sink_valid),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_data    (sink_data),
    .source_eop   (source_eop),
    .source_valid (source_valid),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .underrun     (underrun),
    .missed       (missed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Show-ahead FIFO: pops sampled mid-cycle, applied just after the rising edge.
  initial begin : fifo_model
    bit pop;
    fifo_q     = fifo_val;
    fifo_empty = 1'b0;
    sink_ready = 1'b1;
    forever begin
      @(negedge clk);
      pop = fifo_rdreq;
      if (pop) begin
        check("rdreq_while_empty", fifo_empty, 0);
        check("rdreq_while_idle", busy, 1);
      end
      @(posedge clk);
      #1;
      if (pop && rst_n) begin
        fifo_val++;
        rd_count++;
      end
      if (hole_at >= 0 && int'(fifo_val) == hole_at && hole_done_at != hole_at) begin
        hole_left    = 3;
        hole_done_at = hole_at;
      end
      fifo_empty = (hole_left > 0);
      if (hole_left > 0) hole_left--;
      fifo_q     = fifo_val;
      sink_ready = ready_toggle ? ~sink_ready : 1'b1;
    end
  end

  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
      end else if (sink_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", sink_valid, 0);
        end else begin
          e = exp_q[0];
          check("beat_data", sink_data, e.data);
          check("beat_sop", sink_sop, e.sop);
          check("beat_eop", sink_eop, e.eop);
          if (sink_ready) begin
            void'(exp_q.pop_front());
            if (e.sop) begin
              in_frame = 1'b1;
              bubbles  = 0;
            end
            if (e.eop) in_frame = 1'b0;
          end
        end
      end else if (in_frame) begin
        bubbles++;
      end
    end
  end

  task automatic push_frame();
    beat_t e;
    logic [DW-1:0] base;
    base = fifo_val;
    for (int i = 0; i < NN; i++) begin
      e.data = base + DW'(i);
      e.sop  = (i == 0);
      e.eop  = (i == NN - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_frame();
    push_frame();
    fifo_full = 1'b1;
    step();
    check("start_latency_1", busy, 0);
    step();
    check("start_latency_2", busy, 1);
    fifo_full = 1'b0;
  endtask

  task automatic wait_loaded();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    check("frame_done_in_time", n < 500, 1);
    step();
    check("drain_busy", busy, 1);
    check("drain_valid_low", sink_valid, 0);
  endtask

  task automatic wait_reads(input int r0, input int k);
    int n = 0;
    while (rd_count - r0 < k && n < 200) begin
      step();
      n++;
    end
    check("reads_in_time", n < 200, 1);
  endtask

  task automatic end_frame(input int exp_cnt);
    int n = 0;
    source_valid = 1'b0;
    source_eop   = 1'b1;
    step();
    check("unqualified_eop_cnt", frame_cnt, exp_cnt - 1);
    check("unqualified_eop_busy", busy, 1);
    source_valid = 1'b1;
    step();
    source_valid = 1'b0;
    source_eop   = 1'b0;
    check("frame_cnt", frame_cnt, exp_cnt);
    while (busy && n < 100) begin
      n++;
      step();
    end
    check("gap_cycles", n, EXP_GAP);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int r0;
    rst_n        = 1'b0;
    fifo_full    = 1'b0;
    source_eop   = 1'b0;
    source_valid = 1'b0;
    step(2);
    check("reset_ctrl", {sink_valid, sink_sop, sink_eop, fifo_rdreq, busy, underrun, missed}, 0);
    check("reset_frame_cnt", frame_cnt, 0);
    check("reset_data", sink_data, 0);
    rst_n = 1'b1;
    step(3);
    check("idle_after_reset", busy, 0);

    // Full-rate frame
    r0 = rd_count;
    start_frame();
    wait_loaded();
    check("f1_reads", rd_count - r0, NN);
    check("f1_bubbles", bubbles, 0);
    check("f1_underrun", underrun, 0);
    check("f1_missed", missed, 0);
    end_frame(1);

    // Sink stalls every other cycle
    ready_toggle = 1'b1;
    r0 = rd_count;
    start_frame();
    wait_loaded();
    ready_toggle = 1'b0;
    check("f2_reads", rd_count - r0, NN);
    check("f2_bubbles", bubbles, 0);
    end_frame(2);

    // FIFO runs dry for three cycles at sample 10
    hole_at = int'(fifo_val) + 10;
    r0 = rd_count;
    start_frame();
    wait_loaded();
    check("f3_reads", rd_count - r0, NN);
    check("f3_bubbles", bubbles, 3);
    check("f3_underrun", underrun, 1);

    // Start edge arriving on the cycle the FSM leaves DRAIN
    fifo_full = 1'b1;
    step();
    source_valid = 1'b1;
    source_eop   = 1'b1;
    step();
    source_valid = 1'b0;
    source_eop   = 1'b0;
    fifo_full    = 1'b0;
    check("f3_frame_cnt", frame_cnt, 3);
    check("exit_edge_missed", missed, 1);
    step(EXP_GAP + 5);
    check("exit_edge_no_frame", busy, 0);
    check("exit_edge_no_reads", rd_count - r0, NN);

    // Reset in the middle of a frame
    r0 = rd_count;
    start_frame();
    check("underrun_cleared", underrun, 0);
    wait_reads(r0, 15);
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", {sink_valid, sink_sop, sink_eop, fifo_rdreq, busy, underrun, missed}, 0);
    check("abort_frame_cnt", frame_cnt, 0);
    exp_q.delete();
    step(2);
    rst_n = 1'b1;
    r0 = rd_count;
    step(10);
    check("abort_stays_idle", busy, 0);
    check("abort_no_reads", rd_count - r0, 0);

    // Second start edge during streaming
    r0 = rd_count;
    start_frame();
    wait_reads(r0, 5);
    fifo_full = 1'b1;
    step(3);
    check("busy_edge_missed", missed, 1);
    fifo_full = 1'b0;
    wait_loaded();
    check("f5_reads", rd_count - r0, NN);
    end_frame(1);
    step(10);
    check("no_extra_frame", busy, 0);
    check("no_extra_reads", rd_count - r0, NN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
